ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR, default 8: address width in bits.
REQ-002 Parameter DATA, default 8: data width in bits.
REQ-003 Parameter DEPTH, default 256: memory words; SHALL equal 2**ADDR.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req0_valid  in  1  requester 0 presents a request.
REQ-008 req0_we  in  1  requester 0 direction: 1 = write, 0 = read.
REQ-009 req0_addr  in  ADDR  requester 0 word address.
REQ-010 req0_wdata  in  DATA  requester 0 write data.
REQ-011 req0_ready  out  1  requester 0 request accepted this cycle.
REQ-012 rsp0_valid  out  1  requester 0 read data valid.
REQ-013 rsp0_rdata  out  DATA  requester 0 read data.
REQ-014 req1_*/rsp1_*  same directions and widths as REQ-007..REQ-013, for requester 1.
REQ-015 gnt0_count, gnt1_count  out  16  saturating accepted-request counters, one per requester.
REQ-016 busy  out  1  a read response is pending (pipeline stage occupied).

Function
REQ-017 Handshake: a request transfers on a rising edge where reqN_valid and reqN_ready are both 1; once valid is raised, the requester holds valid, we, addr and wdata stable until accepted.
REQ-018 reqN_ready SHALL be combinational from reqN_valid, the other requester's valid and the priority pointer; at most one ready is high per cycle.
REQ-019 Arbitration: if only one requester is valid, it is granted; if both are valid, the requester named by the priority pointer is granted.
REQ-020 Priority pointer: a 1-bit register; after a grant to requester N it SHALL point to the other requester; it is unchanged in cycles with no grant.
REQ-021 A granted write SHALL update the memory word at the clock edge of acceptance; writes produce no response.
REQ-022 A granted read SHALL assert rspN_valid for exactly one cycle, in the cycle after acceptance (latency 1), with rspN_rdata equal to the memory word at that address.
REQ-023 A response pipeline register SHALL hold the owner ID of the pending read; only the owner's rsp_valid is asserted.
REQ-024 rspN_rdata SHALL be 0 whenever rspN_valid is 0.
REQ-025 Back-to-back reads, including alternating requesters, SHALL be accepted every cycle with no bubble.
REQ-026 A read of an address written in the previous cycle SHALL return the new data.
REQ-027 busy SHALL equal the response-stage valid bit.
REQ-028 gntN_count SHALL increment by 1 on each accepted request from N and SHALL saturate at 16'hFFFF.

Reset
REQ-029 While rst is high: readies 0, rsp*_valid 0, rsp*_rdata 0, busy 0, counters 0, pointer = requester 0.
REQ-030 A read accepted in the cycle in which rst asserts SHALL produce no response.
REQ-031 Memory contents SHALL NOT be reset.

Structure
REQ-032 A shared package ram_arb_pkg SHALL hold the requester-ID typedef (1 bit), the counter width constant (16) and the counter saturation value.
REQ-033 Storage SHALL be the existing single-port memory module ram (synchronous write, registered read, 1-cycle latency), instantiated once; ram_arbiter SHALL drive its write_enable, address and data_in from the granted request.

Verification
REQ-034 After reset, both requesters hold valid=1 with reads of addr 0x10 -> grants alternate 0,1,0,1; each rspN_valid arrives one cycle after its grant.
REQ-035 Requester 0 writes 0xA5 to 0x20; next cycle requester 1 reads 0x20 -> rsp1_valid=1, rsp1_rdata=0xA5, rsp0_valid=0.
REQ-036 Only requester 1 is valid for 5 cycles -> 5 consecutive grants to requester 1; gnt1_count=5, gnt0_count=0.
REQ-037 Force gnt0_count=16'hFFFE, then 3 accepted requests from requester 0 -> count holds at 16'hFFFF.
REQ-038 Assert rst in the cycle after a read is accepted -> rsp0_valid stays 0, busy=0, pointer=0; data previously written at 0x20 still reads back 0xA5 after reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
// Requester IDs, grant-counter width and the saturation helper live here.
package ram_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;

    // Counters stick at CNT_SAT instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram.sv
// Single-port memory: synchronous write, registered read (read-first), 1-cycle latency.
// Contents are deliberately not reset.
module ram #(
    parameter int ADDR  = 8,
    parameter int DATA  = 8,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            write_enable,
    input  logic [ADDR-1:0] address,
    input  logic [DATA-1:0] data_in,
    output logic [DATA-1:0] data_out
);

    logic [DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[address] <= data_in;
        end
        data_out <= mem[address];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with round-robin priority,
// a one-deep read response stage and saturating per-requester grant counters.
//
// Handshake: a request transfers on a rising edge where reqN_valid and reqN_ready
// are both 1; a requester holds valid/we/addr/wdata stable until accepted. Reads
// return rspN_valid for exactly one cycle, one cycle after acceptance; writes
// produce no response.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR  = 8,
    parameter int DATA  = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic             req0_we,
    input  logic [ADDR-1:0]  req0_addr,
    input  logic [DATA-1:0]  req0_wdata,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [DATA-1:0]  rsp0_rdata,

    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic [ADDR-1:0]  req1_addr,
    input  logic [DATA-1:0]  req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [DATA-1:0]  rsp1_rdata,

    output logic [CNT_W-1:0] gnt0_count,
    output logic [CNT_W-1:0] gnt1_count,
    output logic             busy
);

    req_id_t          prio_q;
    logic             rsp_valid_q;
    req_id_t          rsp_id_q;
    logic [CNT_W-1:0] gnt0_cnt_q;
    logic [CNT_W-1:0] gnt1_cnt_q;

    logic             gnt0;
    logic             gnt1;
    logic             grant;
    req_id_t          gnt_id;
    logic             sel_we;
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [DATA-1:0]  mem_wdata;
    logic [DATA-1:0]  mem_rdata;

    // Contention is resolved by the pointer; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && (!req1_valid || prio_q == REQ0)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign grant      = gnt0 | gnt1;
    assign gnt_id     = gnt1 ? REQ1 : REQ0;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign sel_we    = gnt1 ? req1_we    : req0_we;
    assign mem_addr  = gnt1 ? req1_addr  : req0_addr;
    assign mem_wdata = gnt1 ? req1_wdata : req0_wdata;
    assign mem_we    = grant & sel_we;

    ram #(
        .ADDR  (ADDR),
        .DATA  (DATA),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk          (clk),
        .write_enable (mem_we),
        .address      (mem_addr),
        .data_in      (mem_wdata),
        .data_out     (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= REQ0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= REQ0;
            gnt0_cnt_q  <= '0;
            gnt1_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= grant & ~sel_we;
            if (grant) begin
                rsp_id_q <= gnt_id;
                prio_q   <= ~gnt_id;
            end
            if (gnt0) begin
                gnt0_cnt_q <= sat_inc(gnt0_cnt_q);
            end
            if (gnt1) begin
                gnt1_cnt_q <= sat_inc(gnt1_cnt_q);
            end
        end
    end

    // RAM output is unreset, so rdata is gated to zero outside the response cycle.
    assign rsp0_valid = rsp_valid_q && (rsp_id_q == REQ0);
    assign rsp1_valid = rsp_valid_q && (rsp_id_q == REQ1);
    assign rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    assign rsp1_rdata = rsp1_valid ? mem_rdata : '0;

    assign busy       = rsp_valid_q;
    assign gnt0_count = gnt0_cnt_q;
    assign gnt1_count = gnt1_cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: inputs driven on the falling edge, outputs
// sampled 1ns later, each comparison an immediate assertion.
module tb_ram_arbiter;

    localparam int ADDR  = 8;
    localparam int DATA  = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [ADDR-1:0] req0_addr;
    logic [DATA-1:0] req0_wdata, rsp0_rdata;
    logic            req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [ADDR-1:0] req1_addr;
    logic [DATA-1:0] req1_wdata, rsp1_rdata;
    logic [15:0]     gnt0_count, gnt1_count;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR(ADDR), .DATA(DATA), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .gnt0_count (gnt0_count),
        .gnt1_count (gnt1_count),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        // Reset state, with a requester already valid
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_gnt0", gnt0_count, 0);
        check("rst_gnt1", gnt1_count, 0);
        check("rst_prio", dut.prio_q, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Both requesters read 0x10 continuously: grants alternate 0,1,0,1
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h10;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check($sformatf("alt_ready0_%0d", i), req0_ready, (i % 2 == 0));
            check($sformatf("alt_ready1_%0d", i), req1_ready, (i % 2 == 1));
            check($sformatf("alt_rsp0_valid_%0d", i), rsp0_valid, (i > 0) && (i % 2 == 1));
            check($sformatf("alt_rsp1_valid_%0d", i), rsp1_valid, (i > 0) && (i % 2 == 0));
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("alt_last_rsp1_valid", rsp1_valid, 1);
        check("alt_last_rsp0_valid", rsp0_valid, 0);
        check("alt_last_busy", busy, 1);
        check("alt_idle_ready0", req0_ready, 0);
        @(negedge clk);
        #1;
        check("alt_drain_busy", busy, 0);
        check("alt_drain_rsp1_valid", rsp1_valid, 0);
        check("alt_drain_rsp1_rdata", rsp1_rdata, 0);
        check("alt_drain_rsp0_rdata", rsp0_rdata, 0);
        check("alt_gnt0", gnt0_count, 2);
        check("alt_gnt1", gnt1_count, 2);

        // Requester 0 writes 0xA5 to 0x20, requester 1 reads it next cycle
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h20; req0_wdata = 8'hA5;
        #1;
        check("wr_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0; req0_we = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
        #1;
        check("rd_ready1", req1_ready, 1);
        check("wr_no_rsp0", rsp0_valid, 0);
        check("wr_no_busy", busy, 0);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("raw_rsp1_valid", rsp1_valid, 1);
        check("raw_rsp1_rdata", rsp1_rdata, 8'hA5);
        check("raw_rsp0_valid", rsp0_valid, 0);
        check("raw_rsp0_rdata", rsp0_rdata, 0);

        // Reset, then only requester 1 valid for 5 cycles
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                check($sformatf("solo_rsp1_rdata_%0d", i), rsp1_rdata, 8'hA5);
            end
            check($sformatf("solo_ready1_%0d", i), req1_ready, 1);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("solo_gnt1", gnt1_count, 5);
        check("solo_gnt0", gnt0_count, 0);
        check("solo_prio", dut.prio_q, 0);

        // Counter saturation from 0xFFFE
        @(negedge clk);
        force dut.gnt0_cnt_q = 16'hFFFE;
        #1;
        check("sat_forced", gnt0_count, 16'hFFFE);
        @(negedge clk);
        release dut.gnt0_cnt_q;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h30; req0_wdata = 8'h5A;
        #1;
        check("sat_ready0", req0_ready, 1);
        @(negedge clk);
        #1;
        check("sat_after1", gnt0_count, 16'hFFFF);
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req0_we = 1'b0;
        #1;
        check("sat_after3", gnt0_count, 16'hFFFF);

        // Reset asserted in the cycle after a read is accepted
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h20;
        #1;
        check("rr_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
        rst = 1'b1;
        #1;
        check("rr_rsp0_valid", rsp0_valid, 0);
        check("rr_rsp0_rdata", rsp0_rdata, 0);
        check("rr_busy", busy, 0);
        check("rr_prio", dut.prio_q, 0);
        check("rr_gnt0", gnt0_count, 0);
        check("rr_ready1_in_rst", req1_ready, 0);
        @(negedge clk);
        #1;
        check("rr_rsp0_valid_hold", rsp0_valid, 0);
        rst = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h20;
        #1;
        check("post_ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("post_rsp0_valid", rsp0_valid, 1);
        check("post_rsp0_rdata", rsp0_rdata, 8'hA5);
        check("post_rsp1_valid", rsp1_valid, 0);
        check("post_gnt0", gnt0_count, 1);
        @(negedge clk);
        #1;
        check("post_rsp0_single", rsp0_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
